counter_share_sched: RTL and testbench

- Scheduler that shares one up-counter among NREQ requesters.
- Each requester asks for an interval of dur[i] counts.
- The block grants the counter to one requester at a time, using round-robin priority.
- It runs the counter from 0 up to the latched duration, pulses done to the owner, then releases the counter.
- Sits between interval-timing clients and the shared 4-bit up-counter datapath.

---
 rtl/counter_share_sched.sv | 152 +++++++++++++++
 tb/tb_counter_share_sched.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/counter_share_sched.sv
// counter_share_sched
//   Shares one up-counter among NREQ requesters. The counter is granted to
//   one requester at a time in round-robin order. It counts from 0 up to the
//   duration latched at grant time, pulses done to the owner, and is then
//   released.
//
// Ports
//   clk    : system clock, rising edge
//   reset  : asynchronous, active-high
//   req    : [NREQ] per-requester request level
//   dur    : [NREQ*WIDTH] packed durations, requester i at dur[i*WIDTH +: WIDTH]
//   abort  : ends the current interval without done
//   grant  : [NREQ] one-hot owner of the counter, zero when free
//   busy   : high whenever grant is non-zero
//   count  : [WIDTH] shared counter value
//   done   : [NREQ] one-cycle pulse to the owner at interval end
module counter_share_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] dur,
  input  logic                  abort,
  output logic [NREQ-1:0]       grant,
  output logic                  busy,
  output logic [WIDTH-1:0]      count,
  output logic [NREQ-1:0]       done
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic              busy_q,  busy_d;
  logic [WIDTH-1:0]  count_q, count_d;
  logic [NREQ-1:0]   done_q,  done_d;
  logic [WIDTH-1:0]  dur_l_q, dur_l_d;
  logic [IDXW-1:0]   last_q,  last_d;
  logic [IDXW-1:0]   owner_q, owner_d;

  // Round-robin pick: scan last+1, last+2, ... (mod NREQ), first set bit wins.
  // The previous winner is visited last, so it ranks lowest.
  logic            win_found;
  logic [IDXW-1:0] win_idx;

  always_comb begin
    int unsigned idx;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_q) + k) % NREQ;
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_idx   = IDXW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    count_d = count_q;
    done_d  = '0;
    dur_l_d = dur_l_q;
    last_d  = last_q;
    owner_d = owner_q;

    unique case (state_q)
      IDLE: begin
        grant_d = '0;
        busy_d  = 1'b0;
        count_d = '0;
        if (win_found) begin
          grant_d = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
          busy_d  = 1'b1;
          dur_l_d = dur[win_idx*WIDTH +: WIDTH];
          last_d  = win_idx;
          owner_d = win_idx;
          state_d = RUN;
        end
      end

      RUN: begin
        // Release outranks completion: abort on the final count gives no done.
        if (abort || !req[owner_q]) begin
          state_d = IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
          count_d = '0;
        end else if (count_q == dur_l_q) begin
          state_d = DONE;
          done_d  = grant_q;
        end else begin
          count_d = count_q + 1'b1;
        end
      end

      DONE: begin
        // Always a single cycle; abort is not looked at here.
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
        count_d = '0;
      end

      default: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      busy_q  <= 1'b0;
      count_q <= '0;
      done_q  <= '0;
      dur_l_q <= '0;
      last_q  <= IDXW'(NREQ - 1);
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      count_q <= count_d;
      done_q  <= done_d;
      dur_l_q <= dur_l_d;
      last_q  <= last_d;
      owner_q <= owner_d;
    end
  end

  assign grant = grant_q;
  assign busy  = busy_q;
  assign count = count_q;
  assign done  = done_q;

endmodule

// File: tb/tb_counter_share_sched.sv
module tb_counter_share_sched;

  localparam int NREQ  = 4;
  localparam int WIDTH = 4;

  logic                  clk;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] dur;
  logic                  abort;
  logic [NREQ-1:0]       grant;
  logic                  busy;
  logic [WIDTH-1:0]      count;
  logic [NREQ-1:0]       done;

  int n_chk;
  int n_pass;

  counter_share_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .dur   (dur),
    .abort (abort),
    .grant (grant),
    .busy  (busy),
    .count (count),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Check all outputs of one cycle; busy must mirror grant.
  task automatic exp_out(input string tag, input logic [3:0] g, input logic [3:0] c,
                         input logic [3:0] d);
    chk({tag, ".grant"}, 32'(grant), 32'(g));
    chk({tag, ".count"}, 32'(count), 32'(c));
    chk({tag, ".done"},  32'(done),  32'(d));
    chk({tag, ".busy"},  32'(busy),  32'(|g));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dur(input int i, input logic [3:0] v);
    dur[i*WIDTH +: WIDTH] = v;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    reset = 1'b1;
    req   = '0;
    dur   = '0;
    abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_out("rst", 4'b0000, 4'd0, 4'b0000);
    reset = 1'b0;

    // T1: single requester 0, dur 3 -> counts 0..3 then done.
    req = 4'b0001; set_dur(0, 4'd3);
    step(); exp_out("t1.c0", 4'b0001, 4'd0, 4'b0000);
    step(); exp_out("t1.c1", 4'b0001, 4'd1, 4'b0000);
    step(); exp_out("t1.c2", 4'b0001, 4'd2, 4'b0000);
    step(); exp_out("t1.c3", 4'b0001, 4'd3, 4'b0000);
    step(); exp_out("t1.dn", 4'b0001, 4'd3, 4'b0001);
    req = 4'b0000;
    step(); exp_out("t1.rel", 4'b0000, 4'd0, 4'b0000);

    // T2: req 1 and 2 together, round-robin rotation.
    req = 4'b0110; set_dur(1, 4'd1); set_dur(2, 4'd2);
    step(); exp_out("t2.a0", 4'b0010, 4'd0, 4'b0000);
    step(); exp_out("t2.a1", 4'b0010, 4'd1, 4'b0000);
    step(); exp_out("t2.adn", 4'b0010, 4'd1, 4'b0010);
    step(); exp_out("t2.idle", 4'b0000, 4'd0, 4'b0000);
    step(); exp_out("t2.b0", 4'b0100, 4'd0, 4'b0000);
    step(); exp_out("t2.b1", 4'b0100, 4'd1, 4'b0000);
    step(); exp_out("t2.b2", 4'b0100, 4'd2, 4'b0000);
    step(); exp_out("t2.bdn", 4'b0100, 4'd2, 4'b0100);
    step(); exp_out("t2.idle2", 4'b0000, 4'd0, 4'b0000);
    step(); exp_out("t2.again", 4'b0010, 4'd0, 4'b0000);
    req = 4'b0000;
    step(); exp_out("t2.drop", 4'b0000, 4'd0, 4'b0000);

    // T3: dur 0 -> two granted cycles, done on the second.
    req = 4'b1000; set_dur(3, 4'd0);
    step(); exp_out("t3.c0", 4'b1000, 4'd0, 4'b0000);
    step(); exp_out("t3.dn", 4'b1000, 4'd0, 4'b1000);
    req = 4'b0000;
    step(); exp_out("t3.rel", 4'b0000, 4'd0, 4'b0000);

    // T3b: abort on the final count wins over done.
    req = 4'b1000;
    step(); exp_out("t3b.c0", 4'b1000, 4'd0, 4'b0000);
    abort = 1'b1;
    step(); exp_out("t3b.ab", 4'b0000, 4'd0, 4'b0000);
    abort = 1'b0; req = 4'b0000;
    step(); exp_out("t3b.idle", 4'b0000, 4'd0, 4'b0000);

    // T4: max duration counts to all-ones without wrapping.
    req = 4'b0001; set_dur(0, 4'd15);
    for (int i = 0; i < 16; i++) begin
      step(); exp_out($sformatf("tmax.c%0d", i), 4'b0001, 4'(i), 4'b0000);
    end
    step(); exp_out("tmax.dn", 4'b0001, 4'd15, 4'b0001);
    req = 4'b0000;
    step(); exp_out("tmax.rel", 4'b0000, 4'd0, 4'b0000);

    // T5: abort at count 5, pending req 1 served after one idle cycle.
    req = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      step(); exp_out($sformatf("t5.c%0d", i), 4'b0001, 4'(i), 4'b0000);
    end
    abort = 1'b1; req = 4'b0011; set_dur(1, 4'd9);
    step(); exp_out("t5.ab", 4'b0000, 4'd0, 4'b0000);
    abort = 1'b0;
    step(); exp_out("t5.g1", 4'b0010, 4'd0, 4'b0000);

    // T6: async reset mid-interval at count 4; pointer returns to NREQ-1.
    for (int i = 1; i <= 4; i++) begin
      step(); exp_out($sformatf("t6.c%0d", i), 4'b0010, 4'(i), 4'b0000);
    end
    #3 reset = 1'b1;
    #1 exp_out("t6.rst", 4'b0000, 4'd0, 4'b0000);
    @(posedge clk);
    #2 reset = 1'b0;
    step(); exp_out("t6.ptr", 4'b0001, 4'd0, 4'b0000);
    req = 4'b0000;
    step(); exp_out("t6.rel", 4'b0000, 4'd0, 4'b0000);

    // T7: owner drops req at count 2 -> release, no done.
    req = 4'b0100; set_dur(2, 4'd7);
    step(); exp_out("t7.c0", 4'b0100, 4'd0, 4'b0000);
    step(); exp_out("t7.c1", 4'b0100, 4'd1, 4'b0000);
    step(); exp_out("t7.c2", 4'b0100, 4'd2, 4'b0000);
    req = 4'b0000;
    step(); exp_out("t7.drop", 4'b0000, 4'd0, 4'b0000);

    // T8: dur change mid-interval ignored; new request waits, no preemption.
    req = 4'b0100; set_dur(2, 4'd2);
    step(); exp_out("t8.c0", 4'b0100, 4'd0, 4'b0000);
    set_dur(2, 4'd0); req = 4'b0110;
    step(); exp_out("t8.c1", 4'b0100, 4'd1, 4'b0000);
    step(); exp_out("t8.c2", 4'b0100, 4'd2, 4'b0000);
    step(); exp_out("t8.dn", 4'b0100, 4'd2, 4'b0100);
    step(); exp_out("t8.idle", 4'b0000, 4'd0, 4'b0000);
    step(); exp_out("t8.g1", 4'b0010, 4'd0, 4'b0000);
    req = 4'b0000;
    step(); exp_out("t8.rel", 4'b0000, 4'd0, 4'b0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
